// File: rtl/alu_cc_stage_if.sv
// Operand/result bundle between decode operand delivery and the execute-stage
// ALU + condition-code register.
interface alu_cc_stage_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alufun;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic             set_cc;
  logic [3:0]       ifun;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] valE;
  logic             cnd;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  modport master (
    output in_valid, alufun, aluA, aluB, set_cc, ifun, out_ready,
    input  in_ready, out_valid, valE, cnd, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, alufun, aluA, aluB, set_cc, ifun, out_ready,
    output in_ready, out_valid, valE, cnd, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_cc_stage.sv
// Execute-stage ALU with y86 condition-code register: registers valE = B op A
// and the cmov/jXX condition evaluated against the CC held before the bundle.
module alu_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  alu_cc_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  // Handshake: a transfer happens on a rising clk edge where valid & ready are
  // both high; valid never depends on ready, and in_ready = !out_valid | out_ready
  // so a draining result and a new bundle can share the same edge.
  logic             accept;
  logic [WIDTH-1:0] res;
  logic             res_of;
  logic             res_zf;
  logic             res_sf;
  logic             cond;

  logic             out_valid_q;
  logic [WIDTH-1:0] vale_q;
  logic             cnd_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    res    = '0;
    res_of = 1'b0;
    unique case (bus.alufun)
      2'd0: begin
        res    = bus.aluB + bus.aluA;
        res_of = (bus.aluA[MSB] == bus.aluB[MSB]) && (res[MSB] != bus.aluB[MSB]);
      end
      2'd1: begin
        res    = bus.aluB - bus.aluA;
        res_of = (bus.aluA[MSB] != bus.aluB[MSB]) && (res[MSB] != bus.aluB[MSB]);
      end
      2'd2: res = bus.aluB & bus.aluA;
      2'd3: res = bus.aluB ^ bus.aluA;
      default: res = '0;
    endcase
    res_zf = (res == '0);
    res_sf = res[MSB];
  end

  // Condition uses the CC as it stands before this bundle's own flags land.
  always_comb begin
    cond = 1'b0;
    case (bus.ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = (sf_q ^ of_q) | zf_q;
      4'd2: cond = sf_q ^ of_q;
      4'd3: cond = zf_q;
      4'd4: cond = !zf_q;
      4'd5: cond = !(sf_q ^ of_q);
      4'd6: cond = !(sf_q ^ of_q) && !zf_q;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        vale_q      <= res;
        cnd_q       <= cond;
        if (bus.set_cc) begin
          zf_q <= res_zf;
          sf_q <= res_sf;
          of_q <= res_of;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.valE      = vale_q;
  assign bus.cnd       = cnd_q;
  assign bus.cc_zf     = zf_q;
  assign bus.cc_sf     = sf_q;
  assign bus.cc_of     = of_q;
endmodule
